// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory subsystem.
//   lc3b_word   : 16-bit byte address
//   lc3b_data   : 128-bit cache line
//   arb_state_t : mem_arbiter FSM state (IDLE, SERVE_I, SERVE_D)
//   mem_req_t   : the request fields forwarded to memory by the arbiter
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic     we;
    lc3b_word adr;
    lc3b_data wdata;
  } mem_req_t;

  localparam int MEM_REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/arb_watchdog.sv
// Transfer watchdog for mem_arbiter: a saturating cycle counter with a
// compare against the timeout limit.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : force the count to zero (held while the arbiter is idle)
//   inc_i  : advance the count by one this cycle
//   hit_o  : count currently equals TIMEOUT_CYCLES
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      // Stop at all-ones so a stuck count can never wrap back under LIMIT.
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer.
//   sel_i : 0 selects a_i, 1 selects b_i
//   a_i   : input 0
//   b_i   : input 1
//   y_o   : selected value
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one 128-bit line-wide memory port between
// the instruction side (I-cache miss) and the data side (D-cache miss or
// writeback). One single-transfer cyc/stb/ack transaction at a time,
// round-robin on conflict, with a watchdog that aborts a transfer the
// memory never acknowledges.
//
// Handshake: a requester is pending while cyc & stb are high. Once granted,
// mem_cyc/mem_stb stay high until mem_ack (transfer done, x_ack pulses in
// that same cycle), the owner drops cyc (silent abort), or the watchdog
// fires (x_err pulses, timeout_err latches). The cycle after any of these
// is always IDLE.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we/i_adr/i_wdata   instruction-side request
//   i_rdata/i_ack/i_err              instruction-side response
//   d_*                              data-side equivalents
//   mem_cyc/mem_stb/mem_we/mem_adr/mem_wdata  memory request
//   mem_rdata/mem_ack                memory response
//   grant_d                          current owner is the data side
//   timeout_err                      sticky abort-by-timeout flag
//   state_dbg                        FSM state, for debug/checkers
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       reset_n,

  input  logic       i_cyc,
  input  logic       i_stb,
  input  logic       i_we,
  input  lc3b_word   i_adr,
  input  lc3b_data   i_wdata,
  output lc3b_data   i_rdata,
  output logic       i_ack,
  output logic       i_err,

  input  logic       d_cyc,
  input  logic       d_stb,
  input  logic       d_we,
  input  lc3b_word   d_adr,
  input  lc3b_data   d_wdata,
  output lc3b_data   d_rdata,
  output logic       d_ack,
  output logic       d_err,

  output logic       mem_cyc,
  output logic       mem_stb,
  output logic       mem_we,
  output lc3b_word   mem_adr,
  output lc3b_data   mem_wdata,
  input  lc3b_data   mem_rdata,
  input  logic       mem_ack,

  output logic       grant_d,
  output logic       timeout_err,
  output arb_state_t state_dbg
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;   // 1: most recent grant went to D
  logic       terr_q, terr_d;

  logic       i_pend, d_pend;
  logic       serving;
  logic       wd_hit;
  mem_req_t   i_req, d_req, sel_req;

  assign i_pend  = i_cyc & i_stb;
  assign d_pend  = d_cyc & d_stb;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_watchdog (
    .clk_i  (clk),
    .rst_ni (reset_n),
    // Held clear through IDLE, so every grant starts counting from zero.
    .clr_i  (state_q == IDLE),
    .inc_i  (serving && !mem_ack),
    .hit_o  (wd_hit)
  );

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    terr_d   = terr_q;
    i_ack    = 1'b0;
    i_err    = 1'b0;
    d_ack    = 1'b0;
    d_err    = 1'b0;
    case (state_q)
      IDLE: begin
        // On conflict the side that did not win last time goes first.
        if (i_pend && (!d_pend || last_d_q)) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
        end else if (d_pend) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
        end
      end
      SERVE_I: begin
        // Owner abort takes priority: a coincident mem_ack is dropped.
        if (!i_cyc) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          i_ack   = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          i_err   = 1'b1;
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (!d_cyc) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          d_ack   = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          d_err   = 1'b1;
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      terr_q   <= terr_d;
    end
  end

  assign i_req = '{we: i_we, adr: i_adr, wdata: i_wdata};
  assign d_req = '{we: d_we, adr: d_adr, wdata: d_wdata};

  mux2 #(
    .WIDTH (MEM_REQ_W)
  ) u_req_mux (
    .sel_i (grant_d),
    .a_i   (i_req),
    .b_i   (d_req),
    .y_o   (sel_req)
  );

  // Request fields are forced to zero outside a transfer.
  assign mem_cyc     = serving;
  assign mem_stb     = serving;
  assign mem_we      = serving ? sel_req.we    : 1'b0;
  assign mem_adr     = serving ? sel_req.adr   : '0;
  assign mem_wdata   = serving ? sel_req.wdata : '0;

  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign grant_d     = (state_q == SERVE_D);
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import lc3b_types::*;

  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, mem_ack;
  lc3b_word   i_adr, d_adr;
  lc3b_data   i_wdata, d_wdata, mem_rdata;
  lc3b_data   i_rdata, d_rdata, mem_wdata;
  lc3b_word   mem_adr;
  logic       i_ack, i_err, d_ack, d_err;
  logic       mem_cyc, mem_stb, mem_we, grant_d, timeout_err;
  arb_state_t state_dbg;

  mem_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .grant_d(grant_d), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // scoreboard counters and reference-model state
  int   total = 0;
  int   bad = 0;
  logic exp_last_d;   // which side won the most recent grant
  logic exp_terr;     // sticky timeout flag as the model sees it

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled 2 units later
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drop_all();
    i_cyc = 0; i_stb = 0; i_we = 0;
    d_cyc = 0; d_stb = 0; d_we = 0;
    mem_ack = 0;
  endtask

  // round-robin reference: sel 1=I only, 2=D only, 3=both
  function automatic logic pick_d(input int sel, input logic last_d);
    if (sel == 1) return 1'b0;
    if (sel == 2) return 1'b1;
    return !last_d;
  endfunction

  lc3b_data pat_a, pat_b, rd;
  logic     w, win_d, done;
  int       sel, lat;

  initial begin
    drop_all();
    i_adr = '0; d_adr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    pat_a = 128'hA5A5_0000_1111_2222_3333_4444_5555_A5A5;
    pat_b = 128'h0B0B_DEAD_BEEF_CAFE_F00D_1234_5678_0B0B;

    // reset values, with mem_ack forced high to prove acks stay quiet
    #3;
    mem_ack = 1;
    #1;
    chk("rst_state", state_dbg, IDLE);
    chk("rst_mem_cyc", mem_cyc, 0);
    chk("rst_mem_stb", mem_stb, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 0);
    chk("rst_grant_d", grant_d, 0);
    chk("rst_timeout_err", timeout_err, 0);
    mem_ack = 0;
    next_cycle();
    next_cycle();
    reset_n = 1;
    exp_last_d = 1;
    exp_terr = 0;

    // continuous conflict with a 1-cycle memory: I, D, I, D
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1; mem_ack = 1;
    i_adr = 16'h0100; d_adr = 16'h0200;
    settle();
    chk("rr_idle_noack", i_ack | d_ack, 0);
    for (int g = 0; g < 4; g++) begin
      next_cycle(); settle();
      w = pick_d(3, exp_last_d);
      exp_last_d = w;
      chk("rr_stb", mem_stb, 1);
      chk("rr_grant_d", grant_d, w);
      chk("rr_i_ack", i_ack, !w);
      chk("rr_d_ack", d_ack, w);
      chk("rr_adr", mem_adr, w ? 16'h0200 : 16'h0100);
      next_cycle(); settle();
      chk("rr_gap_stb", mem_stb, 0);
      chk("rr_gap_ack", i_ack | d_ack, 0);
    end
    drop_all();

    // single I read, memory acks 3 cycles after mem_stb rose
    next_cycle();
    i_cyc = 1; i_stb = 1; i_adr = 16'h0040;
    settle();
    next_cycle(); settle();
    exp_last_d = 0;
    chk("rd_stb", mem_stb, 1);
    chk("rd_adr", mem_adr, 16'h0040);
    chk("rd_we", mem_we, 0);
    chk("rd_grant_d", grant_d, 0);
    for (int k = 0; k < 2; k++) begin
      next_cycle(); settle();
      chk("rd_wait_ack", i_ack, 0);
      chk("rd_wait_stb", mem_stb, 1);
    end
    next_cycle();
    mem_ack = 1; mem_rdata = pat_a;
    settle();
    chk("rd_i_ack", i_ack, 1);
    chk("rd_i_rdata", i_rdata, pat_a);
    chk("rd_d_rdata", d_rdata, pat_a);
    chk("rd_d_ack", d_ack, 0);
    next_cycle();
    drop_all();
    settle();
    chk("rd_after_state", state_dbg, IDLE);
    chk("rd_after_ack", i_ack, 0);

    // D write
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 16'h1230;
    d_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    settle();
    next_cycle();
    mem_ack = 1;
    settle();
    exp_last_d = 1;
    chk("wr_we", mem_we, 1);
    chk("wr_adr", mem_adr, 16'h1230);
    chk("wr_wdata", mem_wdata, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    chk("wr_grant_d", grant_d, 1);
    chk("wr_d_ack", d_ack, 1);
    chk("wr_i_ack", i_ack, 0);
    next_cycle();
    drop_all();
    settle();

    // abort: I granted, drops cyc as memory acks; pending D follows
    i_cyc = 1; i_stb = 1; i_adr = 16'h0080;
    d_cyc = 1; d_stb = 1; d_adr = 16'h2000;
    settle();
    next_cycle(); settle();
    exp_last_d = 0;
    chk("ab_grant_i", grant_d, 0);
    chk("ab_stb", mem_stb, 1);
    next_cycle();
    i_cyc = 0; i_stb = 0; mem_ack = 1;
    settle();
    chk("ab_no_i_ack", i_ack, 0);
    chk("ab_no_d_ack", d_ack, 0);
    next_cycle();
    mem_ack = 0;
    settle();
    chk("ab_idle", state_dbg, IDLE);
    chk("ab_idle_cyc", mem_cyc, 0);
    next_cycle(); settle();
    exp_last_d = 1;
    chk("ab_d_state", state_dbg, SERVE_D);
    chk("ab_d_adr", mem_adr, 16'h2000);
    mem_ack = 1;
    #1;
    chk("ab_d_ack", d_ack, 1);
    next_cycle();
    drop_all();
    settle();

    // timeout: memory never acks the D request
    d_cyc = 1; d_stb = 1; d_adr = 16'h3000;
    settle();
    exp_last_d = 1;
    for (int k = 0; k <= TO; k++) begin
      next_cycle(); settle();
      chk("to_stb", mem_stb, 1);
      chk("to_d_err", d_err, (k == TO));
      chk("to_i_err", i_err, 0);
    end
    next_cycle();
    drop_all();
    settle();
    exp_terr = 1;
    chk("to_idle", state_dbg, IDLE);
    chk("to_err_pulse", d_err, 0);
    chk("to_sticky", timeout_err, exp_terr);
    i_cyc = 1; i_stb = 1; i_adr = 16'h0440;
    settle();
    next_cycle();
    mem_ack = 1; mem_rdata = pat_b;
    settle();
    exp_last_d = 0;
    chk("to_i_ack", i_ack, 1);
    chk("to_i_rdata", i_rdata, pat_b);
    chk("to_i_err_after", i_err, 0);
    chk("to_sticky2", timeout_err, 1);
    next_cycle();
    drop_all();
    settle();

    // reset pulsed mid-SERVE_D
    d_cyc = 1; d_stb = 1; d_adr = 16'h0800;
    settle();
    next_cycle(); settle();
    chk("mr_serving_d", state_dbg, SERVE_D);
    reset_n = 0;
    #1;
    mem_ack = 1;
    i_cyc = 1; i_stb = 1; i_adr = 16'h0900;
    #1;
    chk("mr_cyc", mem_cyc, 0);
    chk("mr_stb", mem_stb, 0);
    chk("mr_no_d_ack", d_ack, 0);
    chk("mr_state", state_dbg, IDLE);
    chk("mr_terr", timeout_err, 0);
    exp_terr = 0;
    exp_last_d = 1;
    next_cycle();
    next_cycle();
    reset_n = 1;
    mem_ack = 0;
    settle();
    chk("mr_post_idle", state_dbg, IDLE);
    next_cycle(); settle();
    w = pick_d(3, exp_last_d);
    exp_last_d = w;
    chk("mr_first_conflict", grant_d, w);
    chk("mr_first_stb", mem_stb, 1);
    mem_ack = 1;
    #1;
    chk("mr_first_ack", i_ack, !w);
    next_cycle();
    drop_all();
    settle();

    // randomized transactions checked against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(1, 3);
      lat = $urandom_range(0, TO + 2);
      i_adr = 16'($urandom); d_adr = 16'($urandom);
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_wdata = {$urandom, $urandom, $urandom, $urandom};
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
      i_cyc = (sel != 2); i_stb = (sel != 2);
      d_cyc = (sel != 1); d_stb = (sel != 1);
      win_d = pick_d(sel, exp_last_d);
      exp_last_d = win_d;
      settle();
      chk("rnd_idle", state_dbg, IDLE);
      done = 0;
      for (int c = 0; c <= TO; c++) begin
        if (!done) begin
          next_cycle();
          mem_ack = (c == lat);
          rd = {$urandom, $urandom, $urandom, $urandom};
          mem_rdata = rd;
          settle();
          chk("rnd_stb", mem_stb, 1);
          chk("rnd_grant_d", grant_d, win_d);
          chk("rnd_adr", mem_adr, win_d ? d_adr : i_adr);
          chk("rnd_we", mem_we, win_d ? d_we : i_we);
          chk("rnd_wdata", mem_wdata, win_d ? d_wdata : i_wdata);
          chk("rnd_i_ack", i_ack, !win_d && (c == lat));
          chk("rnd_d_ack", d_ack, win_d && (c == lat));
          chk("rnd_i_err", i_err, !win_d && (c == TO) && (lat > TO));
          chk("rnd_d_err", d_err, win_d && (c == TO) && (lat > TO));
          if (c == lat) begin
            chk("rnd_rdata", win_d ? d_rdata : i_rdata, rd);
            done = 1;
          end
        end
      end
      if (lat > TO) exp_terr = 1;
      next_cycle();
      drop_all();
      settle();
      chk("rnd_end_idle", state_dbg, IDLE);
      chk("rnd_terr", timeout_err, exp_terr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
